// File: rtl/mod_updown_counter.sv
// WIDTH-bit up/down counter with programmable modulus, parallel load,
// clock prescaler, one-cycle terminal-count pulse and active-low HEX digits.
module mod_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Enable,
    input  logic                         Up,
    input  logic                         Load,
    input  logic [WIDTH-1:0]             LoadValue,
    input  logic [WIDTH-1:0]             Modulus,
    output logic [WIDTH-1:0]             CounterValue,
    output logic                         TC,
    output logic [7*((WIDTH+3)/4)-1:0]   HEX
);

    localparam int DIGITS = (WIDTH + 3) / 4;
    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     ps_count;
    logic [WIDTH-1:0]    top_value;
    logic [WIDTH-1:0]    next_value;
    logic                wrap;
    logic                step;
    logic [4*DIGITS-1:0] padded;

    // Modulus of zero underflows to all-ones, which gives the full range.
    assign top_value = Modulus - WIDTH'(1);
    assign step      = Enable && (ps_count == PS_LAST);

    always_comb begin
        next_value = CounterValue;
        wrap       = 1'b0;
        if (Up) begin
            if (CounterValue >= top_value) begin
                next_value = '0;
                wrap       = 1'b1;
            end else begin
                next_value = CounterValue + WIDTH'(1);
            end
        end else begin
            if (CounterValue == '0) begin
                next_value = top_value;
                wrap       = 1'b1;
            end else begin
                next_value = CounterValue - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            CounterValue <= '0;
            ps_count     <= '0;
            TC           <= 1'b0;
        end else if (Load) begin
            CounterValue <= LoadValue;
            ps_count     <= '0;
            TC           <= 1'b0;
        end else if (Enable) begin
            if (step) begin
                CounterValue <= next_value;
                ps_count     <= '0;
                TC           <= wrap;
            end else begin
                ps_count     <= ps_count + PS_W'(1);
                TC           <= 1'b0;
            end
        end else begin
            TC <= 1'b0;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0: pattern = 7'b1000000;
            4'h1: pattern = 7'b1111001;
            4'h2: pattern = 7'b0100100;
            4'h3: pattern = 7'b0110000;
            4'h4: pattern = 7'b0011001;
            4'h5: pattern = 7'b0010010;
            4'h6: pattern = 7'b0000010;
            4'h7: pattern = 7'b1111000;
            4'h8: pattern = 7'b0000000;
            4'h9: pattern = 7'b0010000;
            4'hA: pattern = 7'b0001000;
            4'hB: pattern = 7'b0000011;
            4'hC: pattern = 7'b1000110;
            4'hD: pattern = 7'b0100001;
            4'hE: pattern = 7'b0000110;
            default: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // Unused bits of the top nibble read as zero.
    always_comb begin
        padded              = '0;
        padded[WIDTH-1:0]   = CounterValue;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign HEX[7*k +: 7] = seg7(padded[4*k +: 4]);
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed vector table, multi-cycle sequences
// and randomized traffic against an arithmetic reference model.
module tb_mod_updown_counter;

    logic       clock = 1'b0;
    logic       reset, enable, up, load;
    logic [7:0] load_value, modulus;

    logic [7:0]  cv1, cv3, cv4;
    logic [4:0]  cv5;
    logic        tc1, tc3, tc4, tc5;
    logic [13:0] hex1, hex3, hex4, hex5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mod_updown_counter #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .Clock(clock), .Reset(reset), .Enable(enable), .Up(up), .Load(load),
        .LoadValue(load_value), .Modulus(modulus),
        .CounterValue(cv1), .TC(tc1), .HEX(hex1));
    mod_updown_counter #(.WIDTH(8), .PRESCALE(3)) dut3 (
        .Clock(clock), .Reset(reset), .Enable(enable), .Up(up), .Load(load),
        .LoadValue(load_value), .Modulus(modulus),
        .CounterValue(cv3), .TC(tc3), .HEX(hex3));
    mod_updown_counter #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .Clock(clock), .Reset(reset), .Enable(enable), .Up(up), .Load(load),
        .LoadValue(load_value), .Modulus(modulus),
        .CounterValue(cv4), .TC(tc4), .HEX(hex4));
    mod_updown_counter #(.WIDTH(5), .PRESCALE(1)) dut5 (
        .Clock(clock), .Reset(reset), .Enable(enable), .Up(up), .Load(load),
        .LoadValue(load_value[4:0]), .Modulus(modulus[4:0]),
        .CounterValue(cv5), .TC(tc5), .HEX(hex5));

    // Reference model: one entry per DUT instance, plain integer arithmetic.
    int m_width [4] = '{8, 8, 8, 5};
    int m_pre   [4] = '{1, 3, 4, 1};
    int m_cnt   [4];
    int m_ps    [4];
    int m_tc    [4];

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic logic [13:0] hexOf(input int value);
        logic [13:0] h;
        h = '0;
        for (int d = 0; d < 2; d++)
            h[7*d +: 7] = SEG[(value >> (4*d)) & 15];
        return h;
    endfunction

    task automatic modelStep();
        int full, lv, md, m;
        for (int i = 0; i < 4; i++) begin
            full = 1 << m_width[i];
            lv   = int'(load_value) % full;
            md   = int'(modulus) % full;
            m    = (md == 0) ? full : md;
            if (reset) begin
                m_cnt[i] = 0; m_ps[i] = 0; m_tc[i] = 0;
            end else if (load) begin
                m_cnt[i] = lv; m_ps[i] = 0; m_tc[i] = 0;
            end else if (!enable) begin
                m_tc[i] = 0;
            end else if (m_ps[i] == m_pre[i] - 1) begin
                m_ps[i] = 0;
                if (up) begin
                    if (m_cnt[i] + 1 >= m) begin m_cnt[i] = 0; m_tc[i] = 1; end
                    else begin m_cnt[i] = m_cnt[i] + 1; m_tc[i] = 0; end
                end else begin
                    if (m_cnt[i] == 0) begin m_cnt[i] = m - 1; m_tc[i] = 1; end
                    else begin m_cnt[i] = m_cnt[i] - 1; m_tc[i] = 0; end
                end
            end else begin
                m_ps[i] = m_ps[i] + 1;
                m_tc[i] = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("m1_count", int'(cv1), m_cnt[0]);
        checkOutput("m1_tc",    int'(tc1), m_tc[0]);
        checkOutput("m1_hex",   int'(hex1), int'(hexOf(m_cnt[0])));
        checkOutput("m3_count", int'(cv3), m_cnt[1]);
        checkOutput("m3_tc",    int'(tc3), m_tc[1]);
        checkOutput("m3_hex",   int'(hex3), int'(hexOf(m_cnt[1])));
        checkOutput("m4_count", int'(cv4), m_cnt[2]);
        checkOutput("m4_tc",    int'(tc4), m_tc[2]);
        checkOutput("m4_hex",   int'(hex4), int'(hexOf(m_cnt[2])));
        checkOutput("m5_count", int'(cv5), m_cnt[3]);
        checkOutput("m5_tc",    int'(tc5), m_tc[3]);
        checkOutput("m5_hex",   int'(hex5), int'(hexOf(m_cnt[3])));
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then sample.
    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [7:0] lv, input logic [7:0] m);
        reset = r; enable = e; up = u; load = l; load_value = lv; modulus = m;
        @(posedge clock);
        modelStep();
        #1;
        checkAll();
    endtask

    typedef struct {
        logic        r, e, u, l;
        logic [7:0]  lv, m;
        logic [7:0]  exp_count;
        logic        exp_tc;
        logic        chk_hex;
        logic [13:0] exp_hex;
    } vec_t;

    vec_t vecs [20];

    initial begin
        int en_edges;
        int rnd;
        logic [7:0] rmod;

        reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0;
        load_value = '0; modulus = '0;
        for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_ps[i] = 0; m_tc[i] = 0; end

        vecs[0]  = '{1,0,1,0, 8'h00, 8'h00, 8'h00, 0, 1, {7'b1000000, 7'b1000000}};
        vecs[1]  = '{0,1,1,0, 8'h00, 8'h00, 8'h01, 0, 0, 14'h0};
        vecs[2]  = '{0,1,1,0, 8'h00, 8'h00, 8'h02, 0, 0, 14'h0};
        vecs[3]  = '{0,1,1,1, 8'h3C, 8'h00, 8'h3C, 0, 1, {7'b0110000, 7'b1000110}};
        vecs[4]  = '{1,1,1,1, 8'h3C, 8'h00, 8'h00, 0, 0, 14'h0};
        vecs[5]  = '{0,1,1,1, 8'h0F, 8'h0A, 8'h0F, 0, 0, 14'h0};
        vecs[6]  = '{0,1,1,0, 8'h00, 8'h0A, 8'h00, 1, 0, 14'h0};
        vecs[7]  = '{0,1,1,1, 8'h0F, 8'h0A, 8'h0F, 0, 0, 14'h0};
        vecs[8]  = '{0,1,0,0, 8'h00, 8'h0A, 8'h0E, 0, 0, 14'h0};
        vecs[9]  = '{0,0,1,1, 8'h00, 8'h0A, 8'h00, 0, 0, 14'h0};
        vecs[10] = '{0,1,0,0, 8'h00, 8'h0A, 8'h09, 1, 0, 14'h0};
        vecs[11] = '{0,1,0,0, 8'h00, 8'h0A, 8'h08, 0, 0, 14'h0};
        vecs[12] = '{0,0,0,0, 8'h00, 8'h0A, 8'h08, 0, 0, 14'h0};
        vecs[13] = '{0,0,1,1, 8'h01, 8'h01, 8'h01, 0, 0, 14'h0};
        vecs[14] = '{0,1,1,0, 8'h00, 8'h01, 8'h00, 1, 0, 14'h0};
        vecs[15] = '{0,1,1,0, 8'h00, 8'h01, 8'h00, 1, 0, 14'h0};
        vecs[16] = '{0,1,1,1, 8'hFF, 8'h00, 8'hFF, 0, 0, 14'h0};
        vecs[17] = '{0,1,1,0, 8'h00, 8'h00, 8'h00, 1, 0, 14'h0};
        vecs[18] = '{0,1,0,0, 8'h00, 8'h00, 8'hFF, 1, 0, 14'h0};
        vecs[19] = '{0,1,0,0, 8'h00, 8'h00, 8'hFE, 0, 0, 14'h0};

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].l, vecs[i].lv, vecs[i].m);
            checkOutput($sformatf("vec%0d_count", i), int'(cv1), int'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d_tc", i), int'(tc1), int'(vecs[i].exp_tc));
            if (vecs[i].chk_hex)
                checkOutput($sformatf("vec%0d_hex", i), int'(hex1), int'(vecs[i].exp_hex));
        end

        // Full-range 8-bit count through one complete wrap.
        applyStimulus(1, 0, 1, 0, 8'h00, 8'h00);
        for (int k = 1; k <= 260; k++) begin
            applyStimulus(0, 1, 1, 0, 8'h00, 8'h00);
            checkOutput("full_count", int'(cv1), k % 256);
            checkOutput("full_tc", int'(tc1), (k % 256 == 0) ? 1 : 0);
        end

        // Prescale-by-3 modulo-10 up count with an Enable=0 gap.
        applyStimulus(1, 0, 1, 0, 8'h00, 8'h0A);
        en_edges = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n >= 13 && n <= 17) begin
                applyStimulus(0, 0, 1, 0, 8'h00, 8'h0A);
                checkOutput("ps3_tc_frozen", int'(tc3), 0);
            end else begin
                applyStimulus(0, 1, 1, 0, 8'h00, 8'h0A);
                en_edges++;
                checkOutput("ps3_tc", int'(tc3),
                            (en_edges % 3 == 0 && (en_edges / 3) % 10 == 0) ? 1 : 0);
            end
            checkOutput("ps3_count", int'(cv3), (en_edges / 3) % 10);
        end

        // Reset in the middle of a prescale period restarts the period.
        applyStimulus(1, 0, 1, 0, 8'h00, 8'h00);
        applyStimulus(0, 1, 1, 1, 8'h05, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h00, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h00, 8'h00);
        checkOutput("ps4_mid_count", int'(cv4), 5);
        applyStimulus(1, 1, 1, 0, 8'h00, 8'h00);
        checkOutput("ps4_rst_count", int'(cv4), 0);
        checkOutput("ps4_rst_tc", int'(tc4), 0);
        for (int n = 1; n <= 4; n++) begin
            applyStimulus(0, 1, 1, 0, 8'h00, 8'h00);
            checkOutput("ps4_after_rst", int'(cv4), (n == 4) ? 1 : 0);
        end

        // Randomized traffic checked against the model.
        for (int n = 0; n < 1500; n++) begin
            rnd = int'($urandom_range(0, 4));
            case (rnd)
                0: rmod = 8'h00;
                1: rmod = 8'h01;
                2: rmod = 8'h0A;
                3: rmod = 8'h03;
                default: rmod = 8'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 99) < 80),
                          1'($urandom),
                          ($urandom_range(0, 99) < 8),
                          8'($urandom), rmod);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
